// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci job scheduler: FSM state encoding
// and default sizing constants.
package fib_pkg;

    // Default number of requesters sharing the engine (legal range 2..8)
    localparam int DEF_NREQ = 4;
    // Default width of a requested index n
    localparam int DEF_NW   = 5;
    // Default width of the result value
    localparam int DEF_VW   = 13;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } fib_state_t;

    // Round-robin successor of requester index id among nreq requesters
    function automatic int unsigned rr_succ(input int unsigned id, input int unsigned nreq);
        return (id + 1 >= nreq) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/fib_core.sv
// Fibonacci iteration engine: holds prev/cur/cnt, initialises on init,
// advances one term per step, and reports when cnt has reached the
// requested index. With FIB_SCHED_OVF_EN defined it also tracks whether
// prev has ever exceeded the VW-bit range.
module fib_core
    import fib_pkg::*;
#(
    parameter int NW = DEF_NW,
    parameter int VW = DEF_VW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          init,
    input  logic          step,
    input  logic [NW-1:0] n,
    output logic [VW-1:0] prev,
    output logic          at_end,
    output logic          ovf_job
);

    logic [VW-1:0] cur;
    logic [VW-1:0] sum;
    logic [NW-1:0] cnt;

    // Compare before increment so n = 2^NW-1 finishes without cnt wrapping
    assign at_end = (cnt == n);

`ifdef FIB_SCHED_OVF_EN
    logic carry;
    logic cur_ovf;
    logic prev_ovf;

    // Next term with carry out of the VW-bit addition
    always_comb begin
        {carry, sum} = {1'b0, cur} + {1'b0, prev};
    end

    // cur_ovf is sticky over any carry; prev_ovf follows it one term behind,
    // so it only rises once the overflowed term has shifted into prev
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_ovf  <= 1'b0;
            prev_ovf <= 1'b0;
        end else if (init) begin
            cur_ovf  <= 1'b0;
            prev_ovf <= 1'b0;
        end else if (step) begin
            cur_ovf  <= cur_ovf | carry;
            prev_ovf <= cur_ovf;
        end
    end

    assign ovf_job = prev_ovf;
`else
    // Next term, wrapping modulo 2^VW
    always_comb begin
        sum = cur + prev;
    end

    assign ovf_job = 1'b0;
`endif

    // Engine registers: load F(0)/F(1) on init, shift one term per step
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev <= '0;
            cur  <= '0;
            cnt  <= '0;
        end else if (init) begin
            prev <= '0;
            cur  <= VW'(1);
            cnt  <= '0;
        end else if (step) begin
            prev <= cur;
            cur  <= sum;
            cnt  <= cnt + NW'(1);
        end
    end

endmodule

// File: rtl/fib_sched.sv
// Fibonacci job scheduler: round-robin arbitration of NREQ requesters onto
// one shared fib_core, a four-state control FSM and registered result
// outputs. Optional overflow detection/saturation via FIB_SCHED_OVF_EN.
module fib_sched
    import fib_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int NW   = DEF_NW,
    parameter int VW   = DEF_VW
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*NW-1:0]       n_in,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(NREQ)-1:0]  done_id,
    output logic [VW-1:0]            value,
    output logic                     ovf
);

    localparam int IDW = $clog2(NREQ);

    fib_state_t    state;
    fib_state_t    state_next;

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] id_q;
    logic [NW-1:0]  n_q;

    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic [IDW:0]   scan_idx;

    logic           grant_en;
    logic           core_init;
    logic           core_step;
    logic [VW-1:0]  core_prev;
    logic           core_at_end;
    logic           core_ovf;

    // Round-robin pick: first requester set, scanning upward from ptr with wrap
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = {1'b0, ptr} + (IDW+1)'(k);
            if (scan_idx >= (IDW+1)'(NREQ)) begin
                scan_idx = scan_idx - (IDW+1)'(NREQ);
            end
            if (!grant_valid && req[scan_idx[IDW-1:0]]) begin
                grant_valid = 1'b1;
                grant_id    = scan_idx[IDW-1:0];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (grant_valid) state_next = ST_LOAD;
            ST_LOAD: state_next = ST_RUN;
            ST_RUN:  if (core_at_end) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: busy flag and engine/arbiter controls
    always_comb begin
        busy      = (state != ST_IDLE);
        grant_en  = (state == ST_IDLE) && grant_valid;
        core_init = (state == ST_LOAD);
        core_step = (state == ST_RUN) && !core_at_end;
    end

    // Latch winner and its index at grant; later req/n_in changes are ignored
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr  <= '0;
            id_q <= '0;
            n_q  <= '0;
        end else if (grant_en) begin
            ptr  <= IDW'(rr_succ(int'(grant_id), NREQ));
            id_q <= grant_id;
            n_q  <= n_in[grant_id*NW +: NW];
        end
    end

    fib_core #(
        .NW (NW),
        .VW (VW)
    ) u_core (
        .clock   (clock),
        .reset   (reset),
        .init    (core_init),
        .step    (core_step),
        .n       (n_q),
        .prev    (core_prev),
        .at_end  (core_at_end),
        .ovf_job (core_ovf)
    );

    // Result registers: one-cycle done pulse, value/id/ovf held until next job
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done    <= 1'b0;
            done_id <= '0;
            value   <= '0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_DONE) begin
                done    <= 1'b1;
                done_id <= id_q;
                ovf     <= core_ovf;
`ifdef FIB_SCHED_OVF_EN
                value   <= core_ovf ? '1 : core_prev;
`else
                value   <= core_prev;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fib_sched.sv
module tb_fib_sched;

    localparam int NREQ = 4;
    localparam int NW   = 5;
    localparam int VW   = 13;

    logic               clock = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ*NW-1:0] n_in;
    logic               busy;
    logic               done;
    logic [1:0]         done_id;
    logic [VW-1:0]      value;
    logic               ovf;

    int vectors    = 0;
    int miscompares = 0;
    int m_ptr      = 0;   // model round-robin pointer

    fib_sched #(
        .NREQ (NREQ),
        .NW   (NW),
        .VW   (VW)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .n_in    (n_in),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .value   (value),
        .ovf     (ovf)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    function automatic longint fib(input int n);
        longint a = 0;
        longint b = 1;
        longint t;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic logic [VW-1:0] exp_val(input int n);
        longint f = fib(n);
`ifdef FIB_SCHED_OVF_EN
        if (f >= (longint'(1) << VW)) return '1;
`endif
        return VW'(f % (longint'(1) << VW));
    endfunction

    function automatic logic exp_ovf(input int n);
`ifdef FIB_SCHED_OVF_EN
        return fib(n) >= (longint'(1) << VW);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] mask, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Advance edge by edge until done is seen or the budget runs out
    task automatic wait_done(input int limit, output int cyc, output bit got);
        got = 0;
        cyc = 0;
        while (!got && cyc < limit) begin
            @(posedge clock);
            #1;
            cyc++;
            if (done) got = 1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b1;
        req   = '0;
        n_in  = '0;
        #1;
        vectors++;
        if ({busy, done, done_id, value, ovf} !== '0) begin
            miscompares++;
            $display("FAIL reset_async: got busy=%b done=%b id=%0d value=%0d ovf=%b, expected all zero",
                     busy, done, done_id, value, ovf);
        end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        m_ptr = 0;
        @(posedge clock);
        #1;
        vectors++;
        if ({busy, done, done_id, value, ovf} !== '0) begin
            miscompares++;
            $display("FAIL reset_idle: got busy=%b done=%b id=%0d value=%0d ovf=%b, expected all zero",
                     busy, done, done_id, value, ovf);
        end
    endtask

    task automatic test_single_jobs;
        int ids[$] = '{0, 0, 0, 0, 0};
        int ns[$]  = '{10, 0, 1, 20, 31};
        int cyc;
        bit got;
        for (int r = 0; r < 6; r++) begin
            ids.push_back(int'($urandom_range(0, NREQ-1)));
            ns.push_back(int'($urandom_range(0, 2**NW - 1)));
        end
        foreach (ids[j]) begin
            n_in = NREQ*NW'($urandom);
            n_in[ids[j]*NW +: NW] = NW'(ns[j]);
            req = '0;
            req[ids[j]] = 1'b1;
            wait_done(ns[j] + 10, cyc, got);
            req = '0;
            m_ptr = (ids[j] + 1) % NREQ;
            vectors++;
            if (!got) begin
                miscompares++;
                $display("FAIL single_timeout: id=%0d n=%0d no done within %0d cycles", ids[j], ns[j], cyc);
                continue;
            end
            vectors++;
            if (cyc - 1 !== ns[j] + 3) begin
                miscompares++;
                $display("FAIL single_latency: n=%0d got %0d expected %0d", ns[j], cyc - 1, ns[j] + 3);
            end
            vectors++;
            if (value !== exp_val(ns[j])) begin
                miscompares++;
                $display("FAIL single_value: n=%0d got %0d expected %0d", ns[j], value, exp_val(ns[j]));
            end
            vectors++;
            if (done_id !== 2'(ids[j])) begin
                miscompares++;
                $display("FAIL single_id: got %0d expected %0d", done_id, ids[j]);
            end
            vectors++;
            if (ovf !== exp_ovf(ns[j])) begin
                miscompares++;
                $display("FAIL single_ovf: n=%0d got %b expected %b", ns[j], ovf, exp_ovf(ns[j]));
            end
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("FAIL single_busy_at_done: got %b expected 0", busy);
            end
        end
    endtask

    task automatic test_overflow;
        int ns[$] = '{21, 25};
        int cyc;
        bit got;
        ns.push_back(int'($urandom_range(18, 2**NW - 1)));
        foreach (ns[j]) begin
            n_in = '0;
            n_in[3*NW +: NW] = NW'(ns[j]);
            req = 4'b1000;
            wait_done(ns[j] + 10, cyc, got);
            req = '0;
            m_ptr = 0;
            vectors++;
            if (!got) begin
                miscompares++;
                $display("FAIL ovf_timeout: n=%0d no done", ns[j]);
                continue;
            end
            vectors++;
            if (value !== exp_val(ns[j]) || ovf !== exp_ovf(ns[j])) begin
                miscompares++;
                $display("FAIL ovf_result: n=%0d got value=%0d ovf=%b expected value=%0d ovf=%b",
                         ns[j], value, ovf, exp_val(ns[j]), exp_ovf(ns[j]));
            end
        end
    endtask

    task automatic test_drop_req;
        int cyc;
        bit got;
        n_in = '0;
        n_in[1*NW +: NW] = NW'(7);
        req = 4'b0010;
        repeat (3) @(posedge clock);   // grant edge t, then t+1, t+2
        #1;
        req = '0;
        n_in[1*NW +: NW] = NW'($urandom_range(8, 31));
        wait_done(20, cyc, got);
        m_ptr = 2;
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL drop_timeout: no done after req dropped");
        end else begin
            vectors++;
            if (value !== exp_val(7) || done_id !== 2'd1 || cyc + 2 !== 10) begin
                miscompares++;
                $display("FAIL drop_result: got value=%0d id=%0d lat=%0d expected value=%0d id=1 lat=10",
                         value, done_id, cyc + 2, exp_val(7));
            end
        end
    endtask

    task automatic test_reset_mid_job;
        int cyc;
        bit got;
        n_in = '0;
        n_in[0 +: NW] = NW'(25);
        req = 4'b0001;
        repeat (8) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        vectors++;
        if ({busy, done, done_id, value, ovf} !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got busy=%b done=%b id=%0d value=%0d ovf=%b, expected all zero",
                     busy, done, done_id, value, ovf);
        end
        req = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        m_ptr = 0;
        wait_done(40, cyc, got);
        vectors++;
        if (got) begin
            miscompares++;
            $display("FAIL midreset_no_done: got done after abandoned job, expected none");
        end
        n_in = '0;
        n_in[2*NW +: NW] = NW'(5);
        req = 4'b0100;
        wait_done(20, cyc, got);
        req = '0;
        m_ptr = 3;
        vectors++;
        if (!got || done_id !== 2'd2 || value !== exp_val(5) || cyc - 1 !== 8) begin
            miscompares++;
            $display("FAIL midreset_next_job: got done=%b id=%0d value=%0d lat=%0d expected id=2 value=%0d lat=8",
                     got, done_id, value, cyc - 1, exp_val(5));
        end
    endtask

    task automatic test_back_to_back;
        logic [NREQ-1:0] mask;
        int ns[NREQ];
        int cyc;
        bit got;
        int win;
        for (int pass = 0; pass < 2; pass++) begin
            reset = 1'b1;
            @(posedge clock);
            #1;
            reset = 1'b0;
            m_ptr = 0;
            if (pass == 0) begin
                mask = 4'b1111;
                for (int i = 0; i < NREQ; i++) ns[i] = 2;
            end else begin
                mask = NREQ'($urandom_range(1, 2**NREQ - 1));
                for (int i = 0; i < NREQ; i++) ns[i] = int'($urandom_range(0, 15));
            end
            n_in = '0;
            for (int i = 0; i < NREQ; i++) n_in[i*NW +: NW] = NW'(ns[i]);
            req = mask;
            for (int j = 0; j < 5 + pass; j++) begin
                win = rr_pick(mask, m_ptr);
                m_ptr = (win + 1) % NREQ;
                wait_done(ns[win] + 10, cyc, got);
                vectors++;
                if (!got) begin
                    miscompares++;
                    $display("FAIL rr_timeout: pass=%0d job=%0d", pass, j);
                    break;
                end
                vectors++;
                if (done_id !== 2'(win) || value !== exp_val(ns[win])) begin
                    miscompares++;
                    $display("FAIL rr_result: pass=%0d job=%0d got id=%0d value=%0d expected id=%0d value=%0d",
                             pass, j, done_id, value, win, exp_val(ns[win]));
                end
                vectors++;
                if (busy !== 1'b0 || cyc !== ns[win] + 4) begin
                    miscompares++;
                    $display("FAIL rr_gap: pass=%0d job=%0d got busy=%b cycles=%0d expected busy=0 cycles=%0d",
                             pass, j, busy, cyc, ns[win] + 4);
                end
            end
            req = '0;
            repeat (3) @(posedge clock);
            #1;
        end
    endtask

    initial begin
        test_reset;
        test_single_jobs;
        test_overflow;
        test_drop_req;
        test_reset_mid_job;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute safety limit so the run always ends
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
